// File: rtl/blft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blft_pkg
// Description : Shared border-policy constants, FSM encoding and address width
//               helper for the sliding-window generator.
// Revision    : 1.0 - initial release
// ============================================================================
package blft_pkg;

    localparam int BORDER_ZERO = 0;
    localparam int BORDER_REPL = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int addr_w(input int h, input int w);
        return $clog2(h) + $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : blft_addr_gen
// Description : Turns a centre plus signed offsets into an in-image {row,col}
//               address (clamped) and flags coordinates that fell outside.
// Revision    : 1.0 - initial release
// ============================================================================
module blft_addr_gen import blft_pkg::*; #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int OW    = 10
) (
    input  logic [$clog2(IMG_H)-1:0]        row_i,
    input  logic [$clog2(IMG_W)-1:0]        col_i,
    input  logic signed [OW-1:0]            dy_i,
    input  logic signed [OW-1:0]            dx_i,
    output logic [addr_w(IMG_H, IMG_W)-1:0] addr_o,
    output logic                            oor_o
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic signed [OW-1:0] c_RMAX = OW'(IMG_H - 1);
    localparam logic signed [OW-1:0] c_CMAX = OW'(IMG_W - 1);

    logic signed [OW-1:0] w_r;
    logic signed [OW-1:0] w_c;
    logic                 w_r_lo;
    logic                 w_r_hi;
    logic                 w_c_lo;
    logic                 w_c_hi;
    logic [RW-1:0]        w_rc;
    logic [CW-1:0]        w_cc;

    assign w_r    = $signed({{(OW-RW){1'b0}}, row_i}) + dy_i;
    assign w_c    = $signed({{(OW-CW){1'b0}}, col_i}) + dx_i;

    assign w_r_lo = w_r[OW-1];
    assign w_c_lo = w_c[OW-1];
    assign w_r_hi = !w_r_lo && (w_r > c_RMAX);
    assign w_c_hi = !w_c_lo && (w_c > c_CMAX);

    assign w_rc   = w_r_lo ? '0 : (w_r_hi ? RW'(IMG_H - 1) : w_r[RW-1:0]);
    assign w_cc   = w_c_lo ? '0 : (w_c_hi ? CW'(IMG_W - 1) : w_c[CW-1:0]);

    assign addr_o = {w_rc, w_cc};
    assign oor_o  = w_r_lo | w_r_hi | w_c_lo | w_c_hi;

endmodule
`default_nettype wire

// File: rtl/blft_win_gen.sv
`default_nettype none
// ============================================================================
// Module      : blft_win_gen
// Description : Raster-order KxK window generator with one outstanding pixel
//               read, column-reuse shifting and zero/replicate border policy.
// Revision    : 1.0 - initial release
// ============================================================================
module blft_win_gen import blft_pkg::*; #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int PIX_W  = 9,
    parameter int RAD    = 5,
    parameter int BORDER = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   in_req,
    output logic [addr_w(IMG_H, IMG_W)-1:0]        in_addr,
    input  logic                                   in_valid,
    input  logic [PIX_W-1:0]                       in_data,
    output logic                                   win_valid,
    input  logic                                   win_ready,
    output logic [(2*RAD+1)*(2*RAD+1)*PIX_W-1:0]   win_data,
    output logic [addr_w(IMG_H, IMG_W)-1:0]        out_addr,
    output logic                                   win_last
);

    localparam int K  = 2 * RAD + 1;
    localparam int NE = K * K;
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int AW = RW + CW;
    localparam int OW = ((RW > CW) ? RW : CW) + 2;
    localparam int FW = $clog2(K);
    localparam int IW = $clog2(NE);

    state_t                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [FW-1:0]           fx_q, fx_d;
    logic [FW-1:0]           fy_q, fy_d;
    logic [NE-1:0][PIX_W-1:0] win_q, win_d;

    logic signed [OW-1:0]    w_dy;
    logic signed [OW-1:0]    w_dx;
    logic [AW-1:0]           w_fetch_addr;
    logic                    w_oor;
    logic [IW-1:0]           w_idx;
    logic [PIX_W-1:0]        w_pix;
    logic                    w_col_end;
    logic                    w_last_centre;
    logic                    w_col_done;
    logic                    w_win_done;

    // fx/fy index the window slot being filled; offsets are relative to centre
    assign w_dy          = $signed(OW'(fy_q)) - OW'(RAD);
    assign w_dx          = $signed(OW'(fx_q)) - OW'(RAD);
    assign w_idx         = IW'(fy_q) * IW'(K) + IW'(fx_q);
    assign w_pix         = (BORDER == BORDER_ZERO && w_oor) ? '0 : in_data;
    assign w_col_end     = (col_q == CW'(IMG_W - 1));
    assign w_last_centre = (row_q == RW'(IMG_H - 1)) && w_col_end;
    assign w_col_done    = (fy_q == FW'(K - 1));
    assign w_win_done    = w_col_done && (fx_q == FW'(K - 1));

    blft_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .OW    (OW)
    ) u_addr_gen (
        .row_i  (row_q),
        .col_i  (col_q),
        .dy_i   (w_dy),
        .dx_i   (w_dx),
        .addr_o (w_fetch_addr),
        .oor_o  (w_oor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    fx_d    = '0;
                    fy_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (in_valid) begin
                    win_d[w_idx] = w_pix;
                    if (w_col_done) begin
                        fy_d = '0;
                        if (w_win_done) begin
                            state_d = ST_EMIT;
                        end else begin
                            fx_d    = fx_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        fy_d    = fy_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_EMIT: begin
                if (win_ready) begin
                    if (w_last_centre) begin
                        state_d = ST_DONE;
                    end else begin
                        fy_d    = '0;
                        state_d = ST_FETCH;
                        if (w_col_end) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                            fx_d  = '0;
                        end else begin
                            // reuse K-1 columns; only the new right column is fetched
                            col_d = col_q + 1'b1;
                            fx_d  = FW'(K - 1);
                            for (int y = 0; y < K; y++) begin
                                for (int x = 0; x < K - 1; x++) begin
                                    win_d[y*K + x] = win_q[y*K + x + 1];
                                end
                            end
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE);
    assign in_req    = (state_q == ST_FETCH);
    assign in_addr   = w_fetch_addr;
    assign win_valid = (state_q == ST_EMIT);
    assign win_last  = (state_q == ST_EMIT) && w_last_centre;
    assign win_data  = win_q;
    assign out_addr  = {row_q, col_q};

endmodule
`default_nettype wire

// File: tb/tb_blft_win_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_blft_win_gen
// Description : Bench for blft_win_gen on a 4x3 image, RAD=1, with replicate
//               and zero-border instances driven in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blft_win_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int R  = 1;
    localparam int PW = 9;
    localparam int K  = 2 * R + 1;
    localparam int WD = K * K * PW;
    localparam int AW = 4;
    localparam int NW = W * H;

    typedef int arr9_t [9];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          win_ready = 1'b1;

    logic          busy1, done1, req1, wv1, wl1;
    logic [AW-1:0] addr1, oa1;
    logic [WD-1:0] wd1;
    logic          busy0, done0, req0, wv0, wl0;
    logic [AW-1:0] addr0, oa0;
    logic [WD-1:0] wd0;

    int total = 0;
    int bad   = 0;

    arr9_t lit036 = '{0, 0, 1, 0, 0, 1, 16, 16, 17};
    arr9_t lit037 = '{18, 19, 0, 34, 35, 0, 0, 0, 0};
    arr9_t lit038 = '{0, 1, 2, 16, 17, 18, 32, 33, 34};

    always #5 clk = ~clk;

    blft_win_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .RAD(R), .BORDER(1)) dut_repl (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .in_req(req1), .in_addr(addr1), .in_valid(in_valid), .in_data(in_data),
        .win_valid(wv1), .win_ready(win_ready), .win_data(wd1),
        .out_addr(oa1), .win_last(wl1)
    );

    blft_win_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .RAD(R), .BORDER(0)) dut_zero (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
        .in_req(req0), .in_addr(addr0), .in_valid(in_valid), .in_data(in_data),
        .win_valid(wv0), .win_ready(win_ready), .win_data(wd0),
        .out_addr(oa0), .win_last(wl0)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected window straight from the border rules, no knowledge of fetch order
    function automatic logic [WD-1:0] exp_win(input int r, input int c, input int repl);
        logic [WD-1:0] v;
        int rr, cc, p;
        v = '0;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                rr = r + dy;
                cc = c + dx;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    p = 16 * rr + cc;
                else if (repl == 1)
                    p = 16 * (rr < 0 ? 0 : (rr >= H ? H - 1 : rr)) + (cc < 0 ? 0 : (cc >= W ? W - 1 : cc));
                else
                    p = 0;
                v[((dy + R) * K + (dx + R)) * PW +: PW] = p[PW-1:0];
            end
        end
        return v;
    endfunction

    function automatic logic [WD-1:0] pack9(input arr9_t e);
        logic [WD-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[i*PW +: PW] = PW'(e[i]);
        return v;
    endfunction

    // Memory: pixel = 16*row + col, latency 1 or alternating 1/4, optional junk strobes
    logic          pend = 1'b0;
    int            cnt = 0;
    bit            lat_tog = 1'b0;
    bit            alt_lat = 1'b0;
    bit            spur_en = 1'b0;
    logic [AW-1:0] paddr = '0;

    always @(posedge clk) begin
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        if (pend) begin
            if (cnt <= 1) begin
                in_valid = 1'b1;
                in_data  = PW'(16 * int'(paddr[3:2]) + int'(paddr[1:0]));
                pend     = 1'b0;
            end else begin
                cnt--;
            end
        end else if (spur_en && wv1) begin
            in_valid = 1'b1;
            in_data  = '1;
        end
        if (req1) begin
            pend    = 1'b1;
            paddr   = addr1;
            cnt     = (alt_lat && lat_tog) ? 4 : 1;
            lat_tog = !lat_tog;
        end
    end

    bit stall_en = 1'b0;
    int stall_n  = 0;

    always @(posedge clk) begin
        #2;
        if (stall_en && wv1 && oa1 == 4'd5 && stall_n < 5) begin
            win_ready = 1'b0;
            stall_n++;
        end else begin
            win_ready = 1'b1;
        end
    end

    int   acc1 = 0, acc0 = 0, nreq = 0, ndone1 = 0, ndone0 = 0, stall_req = 0;
    logic prev_wv = 1'b0, prev_iv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            acc1    = 0;
            acc0    = 0;
            prev_wv = 1'b0;
            prev_iv = 1'b0;
        end else begin
            if (req1) begin
                nreq++;
                chk("in_addr_row_range", 128'(addr1[3:2] <= 2'd2), 128'(1));
            end
            if (!win_ready && req1) stall_req++;
            if (wv1) begin
                chk("no_req_with_window", 128'(req1), 128'(0));
                if (acc1 >= NW) begin
                    chk("extra_window_repl", 128'(acc1), 128'(NW - 1));
                end else begin
                    chk("win_repl", 128'(wd1), 128'(exp_win(acc1 / W, acc1 % W, 1)));
                    chk("out_addr_repl", 128'(oa1), 128'((acc1 / W) * 4 + acc1 % W));
                    chk("win_last_repl", 128'(wl1), 128'(acc1 == NW - 1));
                    if (acc1 == 0) chk("lit_repl_0_0", 128'(wd1), 128'(pack9(lit036)));
                    if (acc1 == 5) chk("lit_repl_1_1", 128'(wd1), 128'(pack9(lit038)));
                end
                if (!prev_wv) chk("win_valid_after_in_valid", 128'(prev_iv), 128'(1));
                if (win_ready) acc1++;
            end
            if (wv0) begin
                if (acc0 >= NW) begin
                    chk("extra_window_zero", 128'(acc0), 128'(NW - 1));
                end else begin
                    chk("win_zero", 128'(wd0), 128'(exp_win(acc0 / W, acc0 % W, 0)));
                    chk("out_addr_zero", 128'(oa0), 128'((acc0 / W) * 4 + acc0 % W));
                    chk("win_last_zero", 128'(wl0), 128'(acc0 == NW - 1));
                    if (acc0 == NW - 1) chk("lit_zero_2_3", 128'(wd0), 128'(pack9(lit037)));
                end
                if (win_ready) acc0++;
            end
            if (done1) ndone1++;
            if (done0) ndone0++;
            prev_wv = wv1;
            prev_iv = in_valid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl_repl"}, 128'({busy1, done1, req1, wv1, wl1}), 128'(0));
        chk({tag, "_addr_repl"}, 128'({addr1, oa1}), 128'(0));
        chk({tag, "_data_repl"}, 128'(wd1), 128'(0));
        chk({tag, "_ctrl_zero"}, 128'({busy0, done0, req0, wv0, wl0}), 128'(0));
        chk({tag, "_addr_zero"}, 128'({addr0, oa0}), 128'(0));
        chk({tag, "_data_zero"}, 128'(wd0), 128'(0));
    endtask

    task automatic start_frame(input bit extra_start);
        nreq   = 0;
        ndone1 = 0;
        ndone0 = 0;
        acc1   = 0;
        acc0   = 0;
        @(posedge clk); #3 start = 1'b1;
        @(posedge clk); #3 start = 1'b0;
        if (extra_start) begin
            repeat (15) @(posedge clk);
            #3 start = 1'b1;
            @(posedge clk); #3 start = 1'b0;
        end
    endtask

    task automatic finish_frame(input string tag);
        int n;
        n = 0;
        while (ndone1 == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (ndone1 == 0) chk({tag, "_done_timeout"}, 128'(n), 128'(0));
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_req_count"}, 128'(nreq), 128'(54));
        chk({tag, "_windows_repl"}, 128'(acc1), 128'(NW));
        chk({tag, "_windows_zero"}, 128'(acc0), 128'(NW));
        chk({tag, "_done_pulses"}, 128'({ndone1[7:0], ndone0[7:0]}), 128'(16'h0101));
        chk({tag, "_busy_after"}, 128'({busy1, busy0}), 128'(0));
    endtask

    initial begin
        int n;
        #2 rst = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Frame 1: unit latency, 5-cycle backpressure at centre (1,1)
        stall_en = 1'b1;
        start_frame(1'b0);
        finish_frame("f1");
        chk("f1_stall_cycles", 128'(stall_n), 128'(5));
        chk("f1_req_during_stall", 128'(stall_req), 128'(0));
        stall_en = 1'b0;

        // Frame 2: alternating latency, spurious strobes, ignored re-start
        alt_lat = 1'b1;
        spur_en = 1'b1;
        start_frame(1'b1);
        finish_frame("f2");

        // Frame 3: reset after the 7th accepted window, then a clean restart
        start_frame(1'b0);
        n = 0;
        while (acc1 < 7 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (acc1 < 7) chk("f3_seventh_timeout", 128'(acc1), 128'(7));
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (8) @(posedge clk);
        start_frame(1'b0);
        finish_frame("f3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
